// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline stage types and payload constants
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} stage_state_t;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  localparam int IF_ID_W = PC_W + INSTR_W + PC_W;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with clear priority over increment
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_I,
  input  logic             reset_I,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  // count up on inc, stick at all-ones, clr wins
  always_ff @(posedge clk_I)
    count <= reset_I | clr ? '0 : inc & ~&count ? count + 1'b1 : count;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush, optional skid entry and stall counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = IF_ID_W,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk_I,
  input  logic              reset_I,
  input  logic [DATA_W-1:0] data_I,
  input  logic              valid_I,
  output logic              ready_O,
  output logic [DATA_W-1:0] data_O,
  output logic              valid_O,
  input  logic              ready_I,
  input  logic              flush_I,
  input  logic              cnt_clr_I,
  output logic [1:0]        occupancy_O,
  output logic [CNT_W-1:0]  stall_cnt_O
);
  stage_state_t state, state_n;
  logic [DATA_W-1:0] main_q, skid_q;
  logic in_fire, out_fire, ld_in, ld_skid, ld_pop;
  assign valid_O = state != EMPTY;
  assign ready_O = SKID_EN ? state != SKID : !valid_O | ready_I;
  assign in_fire = valid_I & ready_O;
  assign out_fire = valid_O & ready_I;
  assign data_O = main_q;
  assign occupancy_O = state;
  // next state and register load enables; flush drops validity and discards any incoming payload
  always_comb begin
    ld_in = !flush_I & in_fire & (state == EMPTY | state == FULL & out_fire);
    ld_skid = SKID_EN & !flush_I & in_fire & state == FULL & !out_fire;
    ld_pop = !flush_I & out_fire & state == SKID;
    state_n = flush_I ? EMPTY
            : state == EMPTY ? (in_fire ? FULL : EMPTY)
            : state == FULL ? (ld_skid ? SKID : !in_fire & out_fire ? EMPTY : FULL)
            : out_fire ? FULL : SKID;
  end
  // state and payload registers
  always_ff @(posedge clk_I) begin
    state <= reset_I ? EMPTY : state_n;
    main_q <= reset_I ? '0 : ld_in ? data_I : ld_pop ? skid_q : main_q;
    skid_q <= reset_I ? '0 : ld_skid ? data_I : skid_q;
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk_I  (clk_I),
    .reset_I(reset_I),
    .inc    (valid_O & !ready_I),
    .clr    (cnt_clr_I),
    .count  (stall_cnt_O)
  );
  a_hold: assert property (@(posedge clk_I) disable iff (reset_I) valid_O & !ready_I |=> $stable(data_O));
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed table-driven check of skid and pass-through pipeline registers
module tb_pipe_stage_reg;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] a_di, a_do, b_di, b_do;
  logic a_vi, a_ri, a_fl, a_clr, a_ro, a_vo;
  logic b_vi, b_ri, b_ro, b_vo;
  logic [1:0] a_occ, b_occ;
  logic [3:0] a_cnt, b_cnt;
  int checks = 0, errors = 0;
  pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b1), .CNT_W(4)) u_a (
    .clk_I(clk), .reset_I(reset), .data_I(a_di), .valid_I(a_vi), .ready_O(a_ro),
    .data_O(a_do), .valid_O(a_vo), .ready_I(a_ri), .flush_I(a_fl), .cnt_clr_I(a_clr),
    .occupancy_O(a_occ), .stall_cnt_O(a_cnt));
  pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b0), .CNT_W(4)) u_b (
    .clk_I(clk), .reset_I(reset), .data_I(b_di), .valid_I(b_vi), .ready_O(b_ro),
    .data_O(b_do), .valid_O(b_vo), .ready_I(b_ri), .flush_I(1'b0), .cnt_clr_I(1'b0),
    .occupancy_O(b_occ), .stall_cnt_O(b_cnt));
  typedef struct {
    logic v, r, f;
    logic [31:0] d;
    logic ev, erdy;
    logic [31:0] edata;
    logic [1:0] eocc;
  } vec_t;
  function automatic vec_t mk(bit v, bit r, bit f, int d, bit ev, bit erdy, int ed, int eo);
    vec_t x;
    x.v = v; x.r = r; x.f = f; x.d = d;
    x.ev = ev; x.erdy = erdy; x.edata = ed; x.eocc = 2'(eo);
    return x;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  vec_t tbl[15];
  initial begin
    tbl[0]  = mk(1, 1, 0, 1, 1, 1, 1, 1);
    tbl[1]  = mk(1, 1, 0, 2, 1, 1, 2, 1);
    tbl[2]  = mk(1, 1, 0, 3, 1, 1, 3, 1);
    tbl[3]  = mk(1, 0, 0, 4, 1, 0, 3, 2);
    tbl[4]  = mk(1, 0, 0, 5, 1, 0, 3, 2);
    tbl[5]  = mk(1, 1, 0, 5, 1, 1, 4, 1);
    tbl[6]  = mk(1, 1, 0, 5, 1, 1, 5, 1);
    tbl[7]  = mk(0, 1, 0, 0, 0, 1, 5, 0);
    tbl[8]  = mk(1, 0, 0, 6, 1, 1, 6, 1);
    tbl[9]  = mk(1, 0, 0, 7, 1, 0, 6, 2);
    tbl[10] = mk(1, 0, 1, 8, 0, 1, 6, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 1, 6, 0);
    tbl[12] = mk(1, 1, 0, 9, 1, 1, 9, 1);
    tbl[13] = mk(1, 1, 1, 10, 0, 1, 9, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 9, 0);
    a_vi = 1'b1; a_ri = 1'b0; a_fl = 1'b0; a_clr = 1'b0; a_di = 32'h55;
    b_vi = 1'b1; b_ri = 1'b0; b_di = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(a_vo), 64'd0);
    chk("rst_data", 64'(a_do), 64'd0);
    chk("rst_occ", 64'(a_occ), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_b_valid", 64'(b_vo), 64'd0);
    @(negedge clk);
    reset = 1'b0; a_vi = 1'b0; b_vi = 1'b0;
    #1;
    chk("rst_ready", 64'(a_ro), 64'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      a_vi = tbl[i].v; a_ri = tbl[i].r; a_fl = tbl[i].f; a_di = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 64'(a_vo), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), 64'(a_ro), 64'(tbl[i].erdy));
      chk($sformatf("tbl%0d_data", i), 64'(a_do), 64'(tbl[i].edata));
      chk($sformatf("tbl%0d_occ", i), 64'(a_occ), 64'(tbl[i].eocc));
    end
    @(negedge clk);
    a_vi = 1'b1; a_ri = 1'b0; a_fl = 1'b0; a_di = 32'h11; a_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("cnt_cleared", 64'(a_cnt), 64'd0);
    chk("cnt_full", 64'(a_occ), 64'd1);
    @(negedge clk);
    a_vi = 1'b0; a_clr = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("cnt_14", 64'(a_cnt), 64'd14);
    @(posedge clk);
    #1;
    chk("cnt_15", 64'(a_cnt), 64'd15);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_sat", 64'(a_cnt), 64'd15);
    chk("stall_data", 64'(a_do), 64'h11);
    @(negedge clk);
    a_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("cnt_clr", 64'(a_cnt), 64'd0);
    @(negedge clk);
    a_clr = 1'b0; a_vi = 1'b1; a_di = 32'h22;
    @(posedge clk);
    #1;
    chk("cnt_restart", 64'(a_cnt), 64'd1);
    chk("pre_rst_occ", 64'(a_occ), 64'd2);
    @(negedge clk);
    reset = 1'b1; a_fl = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_occ", 64'(a_occ), 64'd0);
    chk("mid_rst_data", 64'(a_do), 64'd0);
    chk("mid_rst_cnt", 64'(a_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0; a_fl = 1'b0; a_vi = 1'b0;
    b_vi = 1'b1; b_ri = 1'b1; b_di = 32'hA1;
    #1;
    chk("b_ready_empty", 64'(b_ro), 64'd1);
    @(posedge clk);
    #1;
    chk("b_data1", 64'(b_do), 64'hA1);
    chk("b_occ1", 64'(b_occ), 64'd1);
    @(negedge clk);
    b_ri = 1'b0; b_di = 32'hA2;
    #1;
    chk("b_ready_comb0", 64'(b_ro), 64'd0);
    @(posedge clk);
    #1;
    chk("b_hold", 64'(b_do), 64'hA1);
    chk("b_occ_hold", 64'(b_occ), 64'd1);
    @(negedge clk);
    b_ri = 1'b1;
    #1;
    chk("b_ready_comb1", 64'(b_ro), 64'd1);
    @(posedge clk);
    #1;
    chk("b_pass", 64'(b_do), 64'hA2);
    chk("b_occ_pass", 64'(b_occ), 64'd1);
    @(negedge clk);
    b_vi = 1'b0;
    @(posedge clk);
    #1;
    chk("b_drain", 64'(b_vo), 64'd0);
    chk("b_occ0", 64'(b_occ), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
